// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, divisor width and receive/transmit state encoding.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_DIV_W     = 24;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous board input; resets to 1 so an idle line reads high.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 frames, MSB first, bit period divisor+1 clocks, valid/ready byte output.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W  = UART_DIV_W,
    parameter int unsigned DATA_W = UART_DATA_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  divisor,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    logic              rx_s;
    uart_state_e       state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              busy_q, busy_d;
    logic [DIV_W-1:0]  half_c;
    logic              deliver_c;

    uart_rx_sync u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    assign half_c = div_q >> 1;

    // Frame FSM, bit timing and output handshake.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver_c   = 1'b0;

        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    div_d   = divisor;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == half_c) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        bit_idx_d = '0;
                        state_d   = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == div_q) begin
                    shift_d   = {shift_q[DATA_W-2:0], rx_s};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_W - 1)) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == div_q) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s) begin
                        deliver_c = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A completed byte replaces the held one only if that one is being accepted now.
        if (deliver_c) begin
            if (!valid_q || data_ready) begin
                data_out_d = shift_q;
                valid_d    = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receive stage. It consumes the line driven by transmitter_uart, or by an external host, on a board pin.
- Frame format, fixed: 1 start bit (0), 8 data bits MSB first, 1 stop bit (1).
- Bit period is divisor+1 clk cycles, the same divisor convention as the transmit path.
- Each received byte is presented on a valid/ready output with framing-error and overrun flags.

Parameters:
- DIV_W, 24, width of divisor input and bit-timing counter
- DATA_W, 8, data bits per frame (only 8 is supported)

Ports:
- clk  input  1  system clock; all logic is on its rising edge
- rst_n  input  1  asynchronous active-low reset
- divisor  input  DIV_W  bit period minus one, in clk cycles; must be >= 3
- rx  input  1  asynchronous serial line; idles high
- data_out  output  8  received byte; stable while data_valid=1
- data_valid  output  1  byte available; held until accepted
- data_ready  input  1  consumer accepts the byte when data_valid & data_ready
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  one-cycle pulse: byte completed while the previous one was still unaccepted
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE; counters=0; synchronizer flops=1.
  - Reset mid-frame abandons the frame; no flags are raised.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- divisor is latched into div_q on leaving IDLE. Changes to divisor mid-frame have no effect until the next frame.
- half = div_q >> 1 (integer). cnt counts 0..div_q.
- IDLE:
  - Stay while rx_s=1.
  - When rx_s=0: latch divisor, cnt<=0, go to START.
- START:
  - Increment cnt.
  - When cnt==half, sample rx_s:
    - rx_s=1: glitch; return to IDLE with no flags raised.
    - rx_s=0: cnt<=0, bit_idx<=0, go to DATA.
- DATA:
  - Increment cnt.
  - When cnt==div_q (one full period after the previous mid-sample): sample rx_s into shift register MSB-first (shift left, new bit into LSB), cnt<=0, bit_idx++.
  - After the 8th sample (bit_idx==7), go to STOP.
  - First received bit ends up at data_out[7].
- STOP:
  - Increment cnt.
  - When cnt==div_q, sample rx_s, then go to IDLE immediately (mid-stop-bit) so a back-to-back start bit is caught.
  - rx_s=1: byte is delivered (see output handshake).
  - rx_s=0: frame_err pulses 1 cycle; byte is discarded; data_valid and data_out are unchanged.
- Output handshake:
  - On delivery with data_valid=0: data_out<=byte, data_valid<=1 on the cycle after the stop sample.
  - On delivery with data_valid=1 & data_ready=1 in the same cycle: new byte is loaded, data_valid stays 1, no overrun.
  - On delivery with data_valid=1 & data_ready=0: overrun pulses 1 cycle; new byte is dropped; old byte is kept.
  - data_valid & data_ready with no delivery: data_valid<=0 next cycle.
  - data_ready while data_valid=0 is ignored.
- Timing:
  - The mid-start sample occurs half+1 cycles after rx_s first reads 0.
  - Each subsequent sample follows the previous one by div_q+1 cycles.
- Width rules:
  - cnt and div_q are DIV_W bits; bit_idx is 3 bits.
  - No arithmetic exceeds DIV_W, so there is no wrap.
- divisor<3 is unsupported; behaviour is unspecified.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams ST_IDLE, ST_START, ST_DATA, ST_STOP (2 bits)
  - UART_DATA_BITS=8
  - UART_DIV_W=24
- transmitter_uart uses the same package.
- One sub-module, uart_rx_sync: 2-flop synchronizer with reset value 1. It is reusable for ICE_SW2 and other board inputs.
- The FSM and bit-timing counter stay inline.

Test Plan:
- Clean byte: divisor=15; transmitter_uart driving rx with 8'b01010101 -> data_out=8'h55, data_valid=1 one cycle after mid-stop; frame_err=0.
- Back-to-back frames with handshake: divisor=15; send 8'hA5 then 8'h3C with no idle gap; data_ready pulses after each valid -> two deliveries in order, no overrun.
- Overrun: send 8'h11 then 8'h22 with data_ready held 0 -> overrun pulses once at the second stop sample; data_out stays 8'h11.
- Framing error: send 8'hF0 with the stop bit forced 0 -> frame_err 1-cycle pulse; data_valid stays 0; receiver returns to IDLE and correctly receives the following 8'h0F.
- Start glitch and divisor change: rx low for 4 cycles with divisor=15 -> no delivery, busy returns 0. Then change divisor from 15 to 7 mid-frame -> frame still decoded at period 16; the next frame uses period 8.
- Reset mid-frame: assert rst_n=0 during DATA bit 4 -> all outputs 0 immediately; after release, the next full frame 8'hC3 is received correctly.
